// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          BCD_DIGITS = 5;
  localparam logic [15:0] BCD_SAT    = 16'h9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble corrector for one BCD digit: adds 3 when the digit is 5 or more,
// so that the following left shift carries cleanly into the next decade.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SAT_EN to report 16'h9999 on bcd whenever ovf is set.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [15:0]      bcd,
  output logic             ovf
);

  localparam int                SCR_W    = 4 * BCD_DIGITS;
  localparam int                CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BIN_W - 1);

  state_t                   state;
  state_t                   state_next;
  logic [SCR_W-1:0]         scratch;
  logic [SCR_W-1:0]         scratch_adj;
  logic [BIN_W-1:0]         shreg;
  logic [CNT_W-1:0]         cnt;
  logic [SCR_W+BIN_W-1:0]   shifted;
  logic [15:0]              bcd_next;
  logic                     ovf_next;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit     (scratch[4*d +: 4]),
      .corrected (scratch_adj[4*d +: 4])
    );
  end

  // Scratch and shift register move as one long word; the scratch MSB drops off.
  assign shifted  = {scratch_adj, shreg} << 1;
  assign ovf_next = (scratch[SCR_W-1:16] != '0);

`ifdef BIN2BCD_SAT_EN
  assign bcd_next = ovf_next ? BCD_SAT : scratch[15:0];
`else
  assign bcd_next = scratch[15:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch <= '0;
      shreg   <= '0;
      cnt     <= '0;
      bcd     <= 16'h0000;
      ovf     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= shifted[SCR_W+BIN_W-1:BIN_W];
          shreg   <= shifted[BIN_W-1:0];
          cnt     <= cnt + CNT_W'(1);
        end
        DONE: begin
          bcd   <= bcd_next;
          ovf   <= ovf_next;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver predicts each accepted conversion
// from decimal arithmetic, and a negedge monitor checks every valid pulse against it.
module tb_bin2bcd_seq;

  localparam int BIN_W   = 16;
  localparam int LATENCY = BIN_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [BIN_W-1:0] bin;
  logic             start;
  logic             busy;
  logic             valid;
  logic [15:0]      bcd;
  logic             ovf;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          due;
    int          value;
  } exp_t;

  exp_t        sb[$];
  int          tests     = 0;
  int          fails     = 0;
  int          edge_n    = 0;
  int          acc       = -100;
  int          next_free = 0;
  logic [15:0] model_bcd = 16'h0000;
  logic        model_ovf = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bin   (bin),
    .start (start),
    .busy  (busy),
    .valid (valid),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always @(posedge clk) edge_n++;

  // Reference: decimal digits of the value, with the ten-thousands part flagged.
  function automatic exp_t refConvert(int value, int due);
    exp_t r;
    int   m;
    m       = value % 10000;
    r.bcd   = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    r.ovf   = (value > 9999);
`ifdef BIN2BCD_SAT_EN
    if (r.ovf) r.bcd = 16'h9999;
`endif
    r.due   = due;
    r.value = value;
    return r;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h (edge %0d)", name, actual, expected, edge_n);
    end
  endtask

  // One cycle of stimulus; a start is accepted once the previous conversion has finished.
  task automatic applyStimulus(int value, bit st);
    int e;
    @(negedge clk);
    bin   = BIN_W'(value);
    start = st;
    e     = edge_n + 1;
    if (st && e >= next_free) begin
      acc       = e;
      next_free = e + LATENCY + 1;
      sb.push_back(refConvert(value, e + LATENCY));
    end
  endtask

  task automatic runOne(int value);
    applyStimulus(value, 1'b1);
    repeat (LATENCY + 2) applyStimulus(0, 1'b0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    start     = 1'b0;
    sb.delete();
    acc       = -100;
    next_free = 0;
    model_bcd = 16'h0000;
    model_ovf = 1'b0;
    #1;
    checkOutput("rst_busy",  32'(busy),  32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_bcd",   32'(bcd),   32'h0000);
    checkOutput("rst_ovf",   32'(ovf),   32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: busy window, valid pulses against the scoreboard, and output hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      checkOutput("busy", 32'(busy), 32'((edge_n >= acc) && (edge_n <= acc + BIN_W)));
      if (valid) begin
        checkOutput("valid_busy_overlap", 32'(busy), 32'd0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", 32'(edge_n), 32'(e.due));
          checkOutput("bcd",     32'(bcd),    32'(e.bcd));
          checkOutput("ovf",     32'(ovf),    32'(e.ovf));
          model_bcd = e.bcd;
          model_ovf = e.ovf;
        end
      end else if (sb.size() > 0 && sb[0].due <= edge_n) begin
        e = sb.pop_front();
        checkOutput("missing_valid", 32'(valid), 32'd1);
        model_bcd = e.bcd;
        model_ovf = e.ovf;
      end
      checkOutput("bcd_hold", 32'(bcd), 32'(model_bcd));
      checkOutput("ovf_hold", 32'(ovf), 32'(model_ovf));
    end
  end

  initial begin
    int v;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("init_busy",  32'(busy),  32'd0);
    checkOutput("init_valid", 32'(valid), 32'd0);
    checkOutput("init_bcd",   32'(bcd),   32'h0000);
    checkOutput("init_ovf",   32'(ovf),   32'd0);
    #1 rst = 1'b0;

    runOne(0);
    runOne(1234);
    runOne(9999);
    runOne(10000);
    runOne(65535);
    runOne(1);

    for (int i = 0; i < 80; i++) applyStimulus(int'($urandom_range(0, 65535)), 1'b1);
    repeat (LATENCY + 2) applyStimulus(0, 1'b0);

    applyStimulus(777, 1'b1);
    repeat (7) applyStimulus(0, 1'b0);
    pulseReset();
    repeat (LATENCY + 3) applyStimulus(0, 1'b0);
    runOne(42);

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0:       v = 9999 + int'($urandom_range(0, 2));
        1:       v = 65535 - int'($urandom_range(0, 3));
        default: v = int'($urandom_range(0, 65535));
      endcase
      applyStimulus(v, 1'b1);
      repeat ($urandom_range(LATENCY, LATENCY + 6))
        applyStimulus(int'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0));
    end

    repeat (LATENCY + 3) applyStimulus(0, 1'b0);
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
